// File: rtl/cla_pkg.sv
// Shared types and default geometry for the cache line adaptor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } cla_state_t;

  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned BURST_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned BEATS       = LINE_W_DEF / BURST_W_DEF;
  localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

endpackage

// File: rtl/cla_beat_counter.sv
// Modulo-BEATS beat counter shared by the read and write burst paths.
module cla_beat_counter #(
  parameter int unsigned BEATS = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache line (LINE_W) to memory burst (BURST_W) adaptor.
// Optional CLA_ADDR_ALIGN_EN forces line-aligned memory addresses.
module cacheline_adaptor
  import cla_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned L_BEATS = LINE_W / BURST_W;
  localparam int unsigned L_CNT_W = (L_BEATS > 1) ? $clog2(L_BEATS) : 1;
  localparam int unsigned OFF_W   = $clog2(LINE_W / 8);

  cla_state_t          r_state;
  cla_state_t          w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_shadow;
  logic [LINE_W-1:0]   r_line_o;
  logic [LINE_W-1:0]   w_shadow_next;
  logic [L_CNT_W-1:0]  w_cnt;
  logic                w_last;
  logic                w_beat;

  assign w_beat = resp_i && ((r_state == READ) || (r_state == WRITE));

  cla_beat_counter #(
    .BEATS (L_BEATS),
    .CNT_W (L_CNT_W)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_beat),
    .i_clr   (r_state == IDLE),
    .o_cnt   (w_cnt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_i) begin
          w_next_state = READ;
        end else if (write_i) begin
          w_next_state = WRITE;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && w_last) w_next_state = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i && w_last) w_next_state = DONE;
      end
      DONE: begin
        resp_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Partial read data lives only in r_shadow; line_o is refreshed once per completed line.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[w_cnt*BURST_W +: BURST_W] = burst_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr   <= '0;
      r_wline  <= '0;
      r_shadow <= '0;
      r_line_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr <= address_i;
          end else if (write_i) begin
            r_addr  <= address_i;
            r_wline <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            r_shadow <= w_shadow_next;
            if (w_last) r_line_o <= w_shadow_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    line_o    = r_line_o;
    burst_o   = r_wline[w_cnt*BURST_W +: BURST_W];
    address_o = r_addr;
`ifdef CLA_ADDR_ALIGN_EN
    address_o[OFF_W-1:0] = '0;
`endif
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int unsigned n_cmp;
  int unsigned n_fail;

  cacheline_adaptor #(
    .LINE_W  (256),
    .BURST_W (64),
    .ADDR_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef CLA_ADDR_ALIGN_EN
    return {a[31:5], 5'b0};
`else
    return a;
`endif
  endfunction

  logic [63:0]  beats_a [4];
  logic [63:0]  beats_b [4];
  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] wline;

  // Runs one full 4-beat read from READ state, checking handshake every cycle.
  task automatic read_burst(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic [255:0] prev_line);
    logic [63:0] bv [4];
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_read_o"}, 256'(read_o), 256'(1'b1));
      check({tag, "_write_o"}, 256'(write_o), 256'(1'b0));
      check({tag, "_line_held"}, line_o, prev_line);
      burst_i = bv[i];
      resp_i  = 1'b1;
      step();
      if (i < 3) check({tag, "_resp_early"}, 256'(resp_o), 256'(1'b0));
    end
    resp_i = 1'b0;
    check({tag, "_resp_done"}, 256'(resp_o), 256'(1'b1));
    check({tag, "_read_o_drop"}, 256'(read_o), 256'(1'b0));
    check({tag, "_line"}, line_o, {b3, b2, b1, b0});
    read_i  = 1'b0;
    write_i = 1'b0;
    step();
    check({tag, "_resp_once"}, 256'(resp_o), 256'(1'b0));
    check({tag, "_idle_read_o"}, 256'(read_o), 256'(1'b0));
    check({tag, "_line_keep"}, line_o, {b3, b2, b1, b0});
  endtask

  initial begin
    logic [63:0] wexp [4];
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    beats_a[0] = 64'h1111_1111_1111_1111; beats_a[1] = 64'h2222_2222_2222_2222;
    beats_a[2] = 64'h3333_3333_3333_3333; beats_a[3] = 64'h4444_4444_4444_4444;
    beats_b[0] = 64'h0123_4567_89AB_CDEF; beats_b[1] = 64'hFEDC_BA98_7654_3210;
    beats_b[2] = 64'h5555_AAAA_5555_AAAA; beats_b[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    line_a = {beats_a[3], beats_a[2], beats_a[1], beats_a[0]};
    line_b = {beats_b[3], beats_b[2], beats_b[1], beats_b[0]};

    step(); step();
    check("rst_read_o", 256'(read_o), 256'(1'b0));
    check("rst_write_o", 256'(write_o), 256'(1'b0));
    check("rst_resp_o", 256'(resp_o), 256'(1'b0));
    check("rst_line_o", line_o, '0);
    check("rst_burst_o", 256'(burst_o), '0);
    check("rst_address_o", 256'(address_o), '0);
    rst = 1'b1;
    step();
    check("idle_read_o", 256'(read_o), 256'(1'b0));

    // Read, no stalls
    address_i = 32'h0000_1234; read_i = 1'b1;
    check("rd_pre_read_o", 256'(read_o), 256'(1'b0));
    step();
    check("rd_address_o", 256'(address_o), 256'(exp_addr(32'h0000_1234)));
    read_burst("rd", beats_a[0], beats_a[1], beats_a[2], beats_a[3], '0);

    // Write with two stall cycles between beats
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wexp[0] = 64'hAAAA_AAAA_AAAA_AAAA; wexp[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wexp[2] = 64'hCCCC_CCCC_CCCC_CCCC; wexp[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    line_i = wline; address_i = 32'h0000_2040; write_i = 1'b1;
    step();
    line_i = '0;
    check("wr_address_o", 256'(address_o), 256'(exp_addr(32'h0000_2040)));
    for (int i = 0; i < 4; i++) begin
      check("wr_write_o", 256'(write_o), 256'(1'b1));
      check("wr_read_o", 256'(read_o), 256'(1'b0));
      check("wr_burst_o", 256'(burst_o), 256'(wexp[i]));
      resp_i = 1'b1;
      step();
      resp_i = 1'b0;
      if (i < 3) begin
        for (int s = 0; s < 2; s++) begin
          check("wr_stall_burst_o", 256'(burst_o), 256'(wexp[i+1]));
          check("wr_stall_write_o", 256'(write_o), 256'(1'b1));
          check("wr_stall_resp_o", 256'(resp_o), 256'(1'b0));
          step();
        end
      end
    end
    check("wr_resp_done", 256'(resp_o), 256'(1'b1));
    check("wr_write_o_drop", 256'(write_o), 256'(1'b0));
    check("wr_line_o_untouched", line_o, line_a);
    write_i = 1'b0;
    step();
    check("wr_resp_once", 256'(resp_o), 256'(1'b0));
    check("wr_idle_write_o", 256'(write_o), 256'(1'b0));

    // Read and write together: read wins
    read_i = 1'b1; write_i = 1'b1; line_i = wline; address_i = 32'h0000_3000;
    step();
    check("both_address_o", 256'(address_o), 256'(exp_addr(32'h0000_3000)));
    read_burst("both", beats_b[0], beats_b[1], beats_b[2], beats_b[3], line_a);
    line_i = '0;

    // Reset in the middle of a read
    read_i = 1'b1; address_i = 32'h0000_4000;
    step();
    for (int i = 0; i < 2; i++) begin
      burst_i = beats_a[i]; resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0; read_i = 1'b0;
    check("mid_read_o", 256'(read_o), 256'(1'b1));
    rst = 1'b0;
    step();
    check("rstmid_read_o", 256'(read_o), 256'(1'b0));
    check("rstmid_resp_o", 256'(resp_o), 256'(1'b0));
    check("rstmid_line_o", line_o, '0);
    check("rstmid_address_o", 256'(address_o), '0);
    rst = 1'b1;
    step();
    check("rstmid_idle_resp_o", 256'(resp_o), 256'(1'b0));
    read_i = 1'b1; address_i = 32'h0000_5000;
    step();
    read_burst("after_rst", beats_b[0], beats_b[1], beats_b[2], beats_b[3], '0);

    // Spurious resp_i in IDLE
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spur_read_o", 256'(read_o), 256'(1'b0));
      check("spur_write_o", 256'(write_o), 256'(1'b0));
      check("spur_resp_o", 256'(resp_o), 256'(1'b0));
      check("spur_line_o", line_o, line_b);
    end
    resp_i = 1'b0;

    // Address alignment behaviour
    read_i = 1'b1; address_i = 32'h0000_103F;
    step();
    check("align_address_o", 256'(address_o), 256'(exp_addr(32'h0000_103F)));
`ifdef CLA_ADDR_ALIGN_EN
    check("align_value", 256'(address_o), 256'(32'h0000_1020));
`else
    check("align_value", 256'(address_o), 256'(32'h0000_103F));
`endif
    read_burst("align", beats_a[0], beats_a[1], beats_a[2], beats_a[3], line_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
